pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the core.
- Consumes the resolved redirect from the branch/jump unit (take_branch, next_pc target).
- Drives instruction-memory requests with a valid/ready handshake and flushes younger pipeline slots on a taken redirect.
- Handles stall, halt and boot, and keeps a saturating taken-redirect counter for performance debug.

Parameters:
PC_W, 10, program counter width; wraps modulo 2^PC_W
RESET_PC, 10'd0, first fetch address after reset
FLUSH_CYCLES, 2, cycles that flush stays high after a taken redirect; legal range 1..7
CNT_W, 16, width of the taken-redirect counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
take_branch  in  1  redirect request from the branch/jump unit
branch_target  in  PC_W  redirect address (branch/jump unit next_pc)
stall  in  1  execute/memory frozen; freezes PC and ignores take_branch
halt_req  in  1  halt instruction reached execute
imem_ready  in  1  instruction memory accepts the address this cycle
imem_addr  out  PC_W  fetch address; always equals pc
imem_valid  out  1  fetch request valid
pc_plus_1  out  PC_W  pc+1 mod 2^PC_W, forwarded to the branch/jump unit
fetch_valid  out  1  the instruction returned this cycle is live for decode
flush  out  1  kill fetch/decode slots
halted  out  1  core halted
taken_cnt  out  CNT_W  count of accepted redirects, saturating

Behaviour:
- Reset, synchronous on clk while rst=1:
  - state=BOOT, pc=RESET_PC, flush_ctr=0, taken_cnt=0.
  - Outputs: imem_valid=0, fetch_valid=0, flush=0, halted=0.
  - rst asserted mid-operation (including in HALT or FLUSH) aborts immediately with the same values.
- States: BOOT, RUN, FLUSH, HALT.
- BOOT: lasts exactly one cycle after rst deasserts, then goes to RUN. imem_valid=0.
- RUN:
  - imem_valid=1.
  - A fetch handshake is imem_valid & imem_ready & ~stall. On a handshake, pc<=pc+1 (wraps 0x3FF->0x000) and fetch_valid=1 in the next cycle.
  - With no handshake, fetch_valid=0 next cycle and pc holds.
- Priority in RUN, highest first: halt_req, then take_branch, then fetch handshake.
  - halt_req=1 & stall=0: state<=HALT, pc holds. A simultaneous take_branch is dropped.
  - take_branch=1 & stall=0:
    - pc<=branch_target, state<=FLUSH, flush_ctr<=FLUSH_CYCLES.
    - taken_cnt<=taken_cnt+1, holding at all-ones.
    - Any fetch handshake in the same cycle is discarded: no pc+1, fetch_valid=0 next cycle.
  - stall=1: pc, state and fetch_valid hold; take_branch and halt_req are ignored. Upstream must hold them until stall drops.
- FLUSH:
  - flush=1 and fetch_valid=0 for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect.
  - imem_valid=1 throughout. Handshakes advance pc normally from the target, but the fetched data is discarded.
  - take_branch is ignored, since flushed slots cannot redirect.
  - halt_req moves to HALT and clears flush.
  - stall does not pause flush_ctr.
  - When flush_ctr reaches 0, return to RUN. The next handshake yields fetch_valid=1.
- HALT: halted=1, imem_valid=0, fetch_valid=0, flush=0. All inputs are ignored; only rst exits.
- pc_plus_1 is combinational from pc. imem_addr is pc.
- All arithmetic is unsigned PC_W-bit with no overflow flag.
- An imem_ready glitch while imem_valid=0 has no effect.

Decomposition:
- common_def holds:
  - the seq_state_e enum {BOOT, RUN, FLUSH, HALT}
  - the PC_W constant, shared with branch_jump (10)
  - RESET_PC
- One natural sub-module: sat_counter (parameter CNT_W; inputs inc, clr; saturating), used for taken_cnt.
- The flush down-counter stays inline.

Test Plan:
- Boot: rst high for 3 cycles, then low, imem_ready=1 -> BOOT for 1 cycle; imem_addr sequence 0,0,1,2,3; fetch_valid first high in cycle 3 after release.
- Wrap: branch to 0x3FE, then free-run -> after the flush, imem_addr 0x3FE,0x3FF,0x000; pc_plus_1=0x000 when pc=0x3FF.
- Redirect: in RUN at pc=0x010, take_branch=1, target=0x200 -> imem_addr=0x200 next cycle; flush=1 for exactly 2 cycles; fetch_valid=0 for those cycles; taken_cnt=1.
- Stall interaction: stall=1 with take_branch=1 for 4 cycles, then stall=0 -> pc frozen during the stall; redirect taken on the first unstalled cycle; taken_cnt increments once.
- Halt priority: halt_req=1 and take_branch=1 in the same cycle -> halted=1, imem_valid=0, pc unchanged, taken_cnt unchanged; further inputs ignored until rst.
- Reset mid-FLUSH and saturation:
  - rst asserted in flush cycle 1 -> flush=0 and pc=RESET_PC next cycle.
  - Force taken_cnt to 0xFFFF, then take another redirect -> taken_cnt stays 0xFFFF.

Source files
------------

// File: rtl/common_def.sv
// Shared core definitions: fetch sequencer states, PC width and boot address.
// Used by the sequencer and the branch/jump unit so both agree on PC geometry.
package common_def;
    localparam int PC_W = 10;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } seq_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency.
// Never wraps: once all-ones it holds until cleared, further incs are dropped.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pc_sequencer.sv
// PC owner and fetch sequencer: one fetch per imem_valid&imem_ready&~stall, data valid next cycle.
// Redirects flush younger slots for FLUSH_CYCLES; stall freezes pc and defers redirect/halt.
module pc_sequencer
    import common_def::*;
#(
    parameter int                    PC_W         = common_def::PC_W,
    parameter logic [PC_W-1:0]       RESET_PC     = common_def::RESET_PC,
    parameter int                    FLUSH_CYCLES = 2,
    parameter int                    CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             take_branch,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             imem_ready,
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_valid,
    output logic [PC_W-1:0]  pc_plus_1,
    output logic             fetch_valid,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] taken_cnt
);
    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      flush_ctr_q, flush_ctr_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            handshake;
    logic            redirect;

    assign imem_valid  = (state_q == RUN) || (state_q == FLUSH);
    assign handshake   = imem_valid & imem_ready & ~stall;
    // halt outranks a same-cycle redirect, so the redirect is not counted
    assign redirect    = (state_q == RUN) & take_branch & ~stall & ~halt_req;

    assign imem_addr   = pc_q;
    assign pc_plus_1   = pc_q + 1'b1;
    assign fetch_valid = fetch_valid_q;
    assign flush       = (state_q == FLUSH);
    assign halted      = (state_q == HALT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_ctr_d   = flush_ctr_q;
        fetch_valid_d = fetch_valid_q;
        case (state_q)
            BOOT: begin
                state_d       = RUN;
                fetch_valid_d = 1'b0;
            end
            RUN: begin
                if (!stall) begin
                    fetch_valid_d = 1'b0;
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (take_branch) begin
                        pc_d        = branch_target;
                        state_d     = FLUSH;
                        flush_ctr_d = 3'(FLUSH_CYCLES);
                    end else if (handshake) begin
                        pc_d          = pc_q + 1'b1;
                        fetch_valid_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // fetches keep streaming from the target; their data is dropped
                fetch_valid_d = 1'b0;
                if (halt_req && !stall) begin
                    state_d     = HALT;
                    flush_ctr_d = '0;
                end else begin
                    if (handshake) begin
                        pc_d = pc_q + 1'b1;
                    end
                    flush_ctr_d = flush_ctr_q - 1'b1;
                    if (flush_ctr_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d       = BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            flush_ctr_q   <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_ctr_q   <= flush_ctr_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk (clk),
        .clr (rst),
        .inc (redirect),
        .cnt (taken_cnt)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a cycle model.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        take_branch;
    logic [9:0]  branch_target;
    logic        stall;
    logic        halt_req;
    logic        imem_ready;
    logic [9:0]  imem_addr;
    logic        imem_valid;
    logic [9:0]  pc_plus_1;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic [15:0] taken_cnt;

    int total = 0;
    int bad   = 0;

    // model: mode 0=boot 1=run 2=flush 3=halt
    int m_mode = 0;
    int m_pc   = 0;
    int m_rem  = 0;
    int m_cnt  = 0;
    int m_fv   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .stall         (stall),
        .halt_req      (halt_req),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .pc_plus_1     (pc_plus_1),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .halted        (halted),
        .taken_cnt     (taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_pc = 0; m_rem = 0; m_cnt = 0; m_fv = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_fv = 0; end
                1: begin
                    if (!stall) begin
                        if (halt_req) begin
                            m_mode = 3; m_fv = 0;
                        end else if (take_branch) begin
                            m_pc   = int'(branch_target);
                            m_mode = 2;
                            m_rem  = 2;
                            m_cnt  = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                            m_fv   = 0;
                        end else begin
                            m_fv = imem_ready ? 1 : 0;
                            if (imem_ready) m_pc = (m_pc + 1) % 1024;
                        end
                    end
                end
                2: begin
                    m_fv = 0;
                    if (halt_req && !stall) begin
                        m_mode = 3;
                    end else begin
                        if (imem_ready && !stall) m_pc = (m_pc + 1) % 1024;
                        m_rem--;
                        if (m_rem == 0) m_mode = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("addr",   imem_addr,   m_pc);
        check("pc_p1",  pc_plus_1,   (m_pc + 1) % 1024);
        check("ivalid", imem_valid,  (m_mode == 1 || m_mode == 2) ? 1 : 0);
        check("fvalid", fetch_valid, m_fv);
        check("flush",  flush,       (m_mode == 2) ? 1 : 0);
        check("halted", halted,      (m_mode == 3) ? 1 : 0);
        check("tcnt",   taken_cnt,   m_cnt);
    endtask

    task automatic step(input logic r, input logic tb, input logic [9:0] tgt,
                        input logic st, input logic hr, input logic rdy);
        @(negedge clk);
        rst = r; take_branch = tb; branch_target = tgt;
        stall = st; halt_req = hr; imem_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int saved_pc;
        int saved_cnt;
        rst = 1'b1; take_branch = 1'b0; branch_target = '0;
        stall = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;

        // boot
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
        check("boot_addr", imem_addr, 0);
        check("boot_ivld", imem_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (i == 0) check("boot_fv_lo", fetch_valid, 0);
            if (i == 1) check("boot_fv_hi", fetch_valid, 1);
        end
        check("boot_addr3", imem_addr, 3);

        // redirect from 0x010
        for (int i = 0; i < 40 && m_pc != 16; i++) step(0, 0, 0, 0, 0, 1);
        check("reach_010", imem_addr, 16);
        step(0, 1, 10'h200, 0, 0, 1);
        check("redir_addr", imem_addr, 10'h200);
        check("redir_fl1", flush, 1);
        step(0, 0, 0, 0, 0, 0);
        check("redir_fl2", flush, 1);
        check("redir_fv", fetch_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        check("redir_fl_end", flush, 0);
        check("redir_cnt", taken_cnt, 1);

        // wrap
        step(0, 1, 10'h3FE, 0, 0, 0);
        check("wrap_3fe", imem_addr, 10'h3FE);
        step(0, 0, 0, 0, 0, 1);
        check("wrap_3ff", imem_addr, 10'h3FF);
        check("wrap_p1", pc_plus_1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

        // stalled redirect
        saved_pc  = m_pc;
        saved_cnt = m_cnt;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 10'h055, 1, 0, 1);
            check("stall_hold", imem_addr, saved_pc);
        end
        step(0, 1, 10'h055, 0, 0, 1);
        check("stall_redir", imem_addr, 10'h055);
        check("stall_cnt", taken_cnt, saved_cnt + 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

        // halt beats branch
        saved_pc  = m_pc;
        saved_cnt = m_cnt;
        step(0, 1, 10'h123, 0, 1, 1);
        check("halt_h", halted, 1);
        check("halt_iv", imem_valid, 0);
        check("halt_pc", imem_addr, saved_pc);
        check("halt_cnt", taken_cnt, saved_cnt);
        for (int i = 0; i < 5; i++)
            step(0, 1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // reset during flush
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 10'h300, 0, 0, 1);
        check("mid_fl", flush, 1);
        step(1, 0, 0, 0, 0, 1);
        check("rstfl_flush", flush, 0);
        check("rstfl_pc", imem_addr, 0);

        // saturation
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        force dut.u_taken_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_taken_cnt.cnt_q;
        m_cnt = 65534;
        step(0, 1, 10'h010, 0, 0, 1);
        check("sat_inc", taken_cnt, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 10'h020, 0, 0, 1);
        check("sat_hold", taken_cnt, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 25,
                 10'($urandom_range(0, 1023)),
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 70);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
